tt_um_l2_onehot_decoder: RTL and testbench
==========================================

// Module: tt_um_l2_onehot_decoder
// PURPOSE
//  Inverse of the l2 16-bit priority encoder: accepts the encoder's 8-bit index code
//  (0x00..0x0F = bit index, 0xF0 = no bit set) under a strobe handshake and rebuilds a
//  16-bit one-hot (replace mode) or OR-accumulated mask in a register.
//  Sits as a Tiny Tapeout top; the mask is read back a byte at a time through uo_out.
// PARAMETERS
//  MASK_W   16   reconstructed mask width; only 16 is supported
//  CNT_W    8    accepted-code counter width; saturating
// PORTS
//  clk      in   1  sole clock
//  rst_n    in   1  reset: synchronous, active-low
//  ena      in   1  design enable; low = no accepts, uo_out/uio_out forced 0
//  ui_in    in   8  code byte, encoder format
//  uio_in   in   8  [0] strobe, [1] accumulate(1)/replace(0), [2] clear, [4:3] byte select, [7:5] unused
//  uo_out   out  8  selected readback byte
//  uio_out  out  8  [3:0]=0; [4] mask!=0, [5] last legal code was 0xF0, [6] sticky error, [7] busy
//  uio_oe   out  8  constant 8'hF0
// BEHAVIOUR
//  Reset (rst_n low at a clk edge): mask=0, code_q=0, count=0, flags=0, state=IDLE; uo_out=0, uio_out=0.
//  FSM: IDLE -> LOAD when strobe=1 & ena=1 (code_q <= ui_in, mode_q <= uio_in[1]).
//       LOAD -> IDLE if strobe=0, else WAIT_LOW; mask/flags/count update on the LOAD->* edge.
//       WAIT_LOW -> IDLE when strobe=0. A held strobe never retriggers.
//  Latency: strobe sampled at edge k; updated mask visible on uo_out after edge k+1.
//  Decode of code_q: [7:4]==0 -> onehot = 1<<code_q[3:0]; replace: mask=onehot; accumulate: mask|=onehot.
//   code_q==0xF0 -> replace: mask=0; accumulate: mask unchanged; none flag=1.
//   Any other value -> mask unchanged, err flag set (sticky), count not incremented.
//   Legal codes set none flag = (code_q==0xF0) and increment count, saturating at 2^CNT_W-1.
//  Clear (uio_in[2]=1): highest priority. mask, count, err, none -> 0. A pending LOAD is dropped.
//   Next state is WAIT_LOW if strobe=1, otherwise IDLE.
//  ena low: IDLE does not leave; LOAD/WAIT_LOW complete normally. uo_out and uio_out read 0.
//  Readback select uio_in[4:3]: 00 mask[7:0], 01 mask[15:8], 10 count, 11 code_q.
//   The mux is combinational off registered state.
//  busy = (state != IDLE).
// CONFIGURATION
//  L2_DEC_COUNT_EN defined: count is implemented; select 10 returns count.
//  Undefined: no counter flops; select 10 returns 8'h00. All other behaviour is identical.
// STRUCTURE
//  Package l2_codec_pkg: NONE_CODE=8'hF0, FSM state encodings (IDLE/LOAD/WAIT_LOW), readback select
//   encodings, uio bit-position constants. Shared with the encoder bench.
//  Sub-module l2_onehot_dec: combinational 4->16 one-hot plus legal/none classification of the code byte.
//  Top contains the FSM, mask/flag/count registers and the readback mux.
// TESTING
//  T1 replace: ui_in=0x05, strobe 1 cycle, sel=00 -> two edges later uo_out=0x20. sel=01 -> 0x00. uio_out[4]=1.
//  T2 accumulate: codes 0x0F, 0x03, 0x08 with mode=1, sel=01 -> 0x81; sel=00 -> 0x08.
//   Count=3 with L2_DEC_COUNT_EN defined.
//  T3 none/illegal: mask=0x0020, replace, code 0xF0 -> mask 0, uio_out[5]=1.
//   Code 0x3C -> mask unchanged, uio_out[6]=1 until clear.
//  T4 held strobe: strobe high for 10 cycles with code 0x02, accumulate -> one accept only, count=1,
//   busy=1 until strobe falls.
//  T5 clear/reset priority: clear asserted in the LOAD cycle -> mask stays 0, count 0.
//   rst_n low mid-WAIT_LOW -> all outputs 0 on the next edge.
//  T6 ena low: strobe pulses ignored, uo_out=0. ena high -> prior mask readable unchanged.
//   Check sel=10 returns 0x00 when the macro is undefined.

Source files
------------

// File: rtl/l2_codec_pkg.sv
// Shared definitions for the l2 priority encoder / one-hot decoder pair.
// Holds the "no bit set" code, decoder FSM state encoding, readback select
// encodings and the bit positions used on the Tiny Tapeout uio bus.
// Optional feature macro used by the decoder: L2_DEC_COUNT_EN.
package l2_codec_pkg;

  // Encoder output when none of the 16 inputs is set.
  localparam logic [7:0] NONE_CODE = 8'hF0;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StWaitLow = 2'd2
  } dec_state_e;

  typedef enum logic [1:0] {
    SelMaskLo = 2'b00,
    SelMaskHi = 2'b01,
    SelCount  = 2'b10,
    SelCode   = 2'b11
  } rb_sel_e;

  // uio_in bit positions
  localparam int unsigned UioStrobe = 0;
  localparam int unsigned UioAccum  = 1;
  localparam int unsigned UioClear  = 2;
  localparam int unsigned UioSelLsb = 3;

  // uio_out bit positions
  localparam int unsigned UioMaskNz = 4;
  localparam int unsigned UioNone   = 5;
  localparam int unsigned UioErr    = 6;
  localparam int unsigned UioBusy   = 7;

  localparam logic [7:0] UioOe = 8'hF0;

  // True when the code names a single bit index (0x00..0x0F).
  function automatic logic is_bit_code(input logic [7:0] code);
    return code[7:4] == 4'h0;
  endfunction

endpackage

// File: rtl/l2_onehot_dec.sv
// Combinational classifier / decoder for one encoder code byte.
//   code    in  8   encoder-format code
//   onehot  out 16  1 << code[3:0] for a bit code, otherwise 0
//   legal   out 1   code is a bit index or NONE_CODE
//   none    out 1   code is NONE_CODE
module l2_onehot_dec
  import l2_codec_pkg::*;
(
  input  logic [7:0]  code,
  output logic [15:0] onehot,
  output logic        legal,
  output logic        none
);

  logic bit_code;

  assign bit_code = is_bit_code(code);
  assign none     = (code == NONE_CODE);
  assign legal    = bit_code | none;
  assign onehot   = bit_code ? (16'h0001 << code[3:0]) : 16'h0000;

endmodule

// File: rtl/tt_um_l2_onehot_decoder.sv
// Tiny Tapeout top: rebuilds a 16-bit one-hot / OR-accumulated mask from l2
// encoder codes presented under a strobe handshake; readback one byte at a time.
//   clk, rst_n     clock, synchronous active-low reset
//   ena            enable; low blocks new accepts and forces uo_out/uio_out to 0
//   ui_in[7:0]     code byte
//   uio_in         [0] strobe, [1] accumulate, [2] clear, [4:3] readback select
//   uo_out[7:0]    selected byte: mask lo, mask hi, count, last code
//   uio_out        [4] mask!=0, [5] none, [6] sticky error, [7] busy
//   uio_oe         constant 8'hF0
// Macro L2_DEC_COUNT_EN: implements the saturating accepted-code counter;
// without it the count readback is 8'h00 and no counter flops exist.
module tt_um_l2_onehot_decoder
  import l2_codec_pkg::*;
#(
  parameter int unsigned MASK_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  dec_state_e        state_q, state_d;
  logic [7:0]        code_q, code_d;
  logic              mode_q, mode_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              err_q, err_d;
  logic              none_q, none_d;
  logic [CNT_W-1:0]  count_q;

  logic        strobe, accum, clear;
  rb_sel_e     sel;
  logic [15:0] onehot;
  logic        legal, is_none;
  logic [7:0]  rb;
  logic        unused;

  assign strobe = uio_in[UioStrobe];
  assign accum  = uio_in[UioAccum];
  assign clear  = uio_in[UioClear];
  assign sel    = rb_sel_e'(uio_in[UioSelLsb +: 2]);
  assign unused = ^uio_in[7:5];

  // Decode the latched code, not ui_in, so the update uses the accepted value.
  l2_onehot_dec u_dec (
    .code   (code_q),
    .onehot (onehot),
    .legal  (legal),
    .none   (is_none)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    err_d   = err_q;
    none_d  = none_q;
    if (clear) begin
      // Clear beats any pending LOAD; a still-high strobe must fall before re-arming.
      mask_d  = '0;
      err_d   = 1'b0;
      none_d  = 1'b0;
      state_d = strobe ? StWaitLow : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (strobe && ena) begin
            state_d = StLoad;
            code_d  = ui_in;
            mode_d  = accum;
          end
        end
        StLoad: begin
          if (legal) begin
            if (!is_none) begin
              mask_d = mode_q ? (mask_q | onehot) : onehot;
            end else if (!mode_q) begin
              mask_d = '0;
            end
            none_d = is_none;
          end else begin
            err_d = 1'b1;
          end
          state_d = strobe ? StWaitLow : StIdle;
        end
        StWaitLow: begin
          if (!strobe) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= '0;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      none_q  <= none_d;
    end
  end

`ifdef L2_DEC_COUNT_EN
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (state_q == StLoad && legal && count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
`else
  assign count_q = '0;
`endif

  always_comb begin
    rb = '0;
    unique case (sel)
      SelMaskLo: rb = mask_q[7:0];
      SelMaskHi: rb = mask_q[15:8];
      SelCount:  rb = 8'(count_q);
      SelCode:   rb = code_q;
    endcase
  end

  always_comb begin
    uio_out = '0;
    if (ena) begin
      uio_out[UioMaskNz] = |mask_q;
      uio_out[UioNone]   = none_q;
      uio_out[UioErr]    = err_q;
      uio_out[UioBusy]   = (state_q != StIdle);
    end
  end

  assign uo_out = ena ? rb : 8'h00;
  assign uio_oe = UioOe;

endmodule

// File: tb/tb_tt_um_l2_onehot_decoder.sv
module tb_tt_um_l2_onehot_decoder;

`ifdef L2_DEC_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic       strobe, accum, clr;
  logic [1:0] sel;

  int checks = 0;
  int errors = 0;

  assign uio_in = {3'b000, sel, clr, accum, strobe};

  tt_um_l2_onehot_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe pulse; the update lands on the second edge.
  task automatic send(input logic [7:0] code, input logic acc);
    ui_in = code; accum = acc; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; strobe = 0; accum = 0; clr = 0; sel = 2'b00;
    tick(); tick();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo: got %h exp 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio: got %h exp 00", uio_out); end
    checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL reset_oe: got %h exp f0", uio_oe); end
    rst_n = 1'b1;
    tick();
    sel = 2'b11; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_code: got %h exp 00", uo_out); end
    sel = 2'b00;
  endtask

  task automatic test_replace();
    ui_in = 8'h05; accum = 1'b0; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t1_early: got %h exp 00", uo_out); end
    checks++; if (uio_out !== 8'h80) begin errors++; $display("FAIL t1_busy: got %h exp 80", uio_out); end
    tick();
    checks++; if (uo_out !== 8'h20) begin errors++; $display("FAIL t1_lo: got %h exp 20", uo_out); end
    checks++; if (uio_out !== 8'h10) begin errors++; $display("FAIL t1_flags: got %h exp 10", uio_out); end
    sel = 2'b01; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t1_hi: got %h exp 00", uo_out); end
    sel = 2'b00;
  endtask

  task automatic test_accumulate();
    pulse_clear();
    send(8'h0F, 1'b1);
    send(8'h03, 1'b1);
    send(8'h08, 1'b1);
    sel = 2'b01; #1;
    checks++; if (uo_out !== 8'h81) begin errors++; $display("FAIL t2_hi: got %h exp 81", uo_out); end
    sel = 2'b00; #1;
    checks++; if (uo_out !== 8'h08) begin errors++; $display("FAIL t2_lo: got %h exp 08", uo_out); end
    sel = 2'b10; #1;
    checks++; if (uo_out !== (CntEn ? 8'd3 : 8'd0)) begin
      errors++; $display("FAIL t2_count: got %h exp %h", uo_out, CntEn ? 8'd3 : 8'd0);
    end
    sel = 2'b11; #1;
    checks++; if (uo_out !== 8'h08) begin errors++; $display("FAIL t2_code: got %h exp 08", uo_out); end
    sel = 2'b00;
  endtask

  task automatic test_none_illegal();
    pulse_clear();
    send(8'h05, 1'b0);
    send(8'hF0, 1'b0);
    #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t3_none_mask: got %h exp 00", uo_out); end
    checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL t3_none_flag: got %h exp 20", uio_out); end
    send(8'h05, 1'b0);
    send(8'h3C, 1'b0);
    checks++; if (uo_out !== 8'h20) begin errors++; $display("FAIL t3_ill_mask: got %h exp 20", uo_out); end
    checks++; if (uio_out !== 8'h50) begin errors++; $display("FAIL t3_ill_flag: got %h exp 50", uio_out); end
    send(8'h01, 1'b0);
    checks++; if (uo_out !== 8'h02) begin errors++; $display("FAIL t3_after_mask: got %h exp 02", uo_out); end
    checks++; if (uio_out !== 8'h50) begin errors++; $display("FAIL t3_sticky: got %h exp 50", uio_out); end
    sel = 2'b10; #1;
    checks++; if (uo_out !== (CntEn ? 8'd4 : 8'd0)) begin
      errors++; $display("FAIL t3_count: got %h exp %h", uo_out, CntEn ? 8'd4 : 8'd0);
    end
    sel = 2'b00;
    send(8'hF0, 1'b1);
    checks++; if (uo_out !== 8'h02) begin errors++; $display("FAIL t3_acc_none: got %h exp 02", uo_out); end
    checks++; if (uio_out !== 8'h70) begin errors++; $display("FAIL t3_acc_flag: got %h exp 70", uio_out); end
    pulse_clear();
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL t3_clr_flag: got %h exp 00", uio_out); end
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t3_clr_mask: got %h exp 00", uo_out); end
  endtask

  task automatic test_held_strobe();
    ui_in = 8'h02; accum = 1'b1; strobe = 1'b1;
    tick(); tick();
    ui_in = 8'h07;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (uo_out !== 8'h04) begin errors++; $display("FAIL t4_mask: got %h exp 04", uo_out); end
    checks++; if (uio_out !== 8'h90) begin errors++; $display("FAIL t4_busy: got %h exp 90", uio_out); end
    sel = 2'b11; #1;
    checks++; if (uo_out !== 8'h02) begin errors++; $display("FAIL t4_code: got %h exp 02", uo_out); end
    strobe = 1'b0;
    tick();
    checks++; if (uio_out !== 8'h10) begin errors++; $display("FAIL t4_idle: got %h exp 10", uio_out); end
    sel = 2'b10; #1;
    checks++; if (uo_out !== (CntEn ? 8'd1 : 8'd0)) begin
      errors++; $display("FAIL t4_count: got %h exp %h", uo_out, CntEn ? 8'd1 : 8'd0);
    end
    sel = 2'b00;
  endtask

  task automatic test_clear_priority();
    pulse_clear();
    ui_in = 8'h09; accum = 1'b0; strobe = 1'b1;
    tick();
    strobe = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t5_lo: got %h exp 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL t5_flags: got %h exp 00", uio_out); end
    sel = 2'b01; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t5_hi: got %h exp 00", uo_out); end
    sel = 2'b10; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t5_count: got %h exp 00", uo_out); end
    sel = 2'b01;
    send(8'h09, 1'b0);
    checks++; if (uo_out !== 8'h02) begin errors++; $display("FAIL t5_pre_hi: got %h exp 02", uo_out); end
    ui_in = 8'h01; strobe = 1'b1;
    tick(); tick();
    checks++; if (uio_out !== 8'h90) begin errors++; $display("FAIL t5_wait: got %h exp 90", uio_out); end
    rst_n = 1'b0;
    sel = 2'b00;
    tick();
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t5_rst_lo: got %h exp 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL t5_rst_uio: got %h exp 00", uio_out); end
    sel = 2'b11; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t5_rst_code: got %h exp 00", uo_out); end
    strobe = 1'b0; sel = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ena_low();
    send(8'h0A, 1'b0);
    ena = 1'b0; sel = 2'b01; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t6_uo_off: got %h exp 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL t6_uio_off: got %h exp 00", uio_out); end
    send(8'h01, 1'b0);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t6_uo_pulse: got %h exp 00", uo_out); end
    ena = 1'b1; #1;
    checks++; if (uo_out !== 8'h04) begin errors++; $display("FAIL t6_hi: got %h exp 04", uo_out); end
    checks++; if (uio_out !== 8'h10) begin errors++; $display("FAIL t6_flags: got %h exp 10", uio_out); end
    sel = 2'b11; #1;
    checks++; if (uo_out !== 8'h0A) begin errors++; $display("FAIL t6_code: got %h exp 0a", uo_out); end
    sel = 2'b10; #1;
    checks++; if (uo_out !== (CntEn ? 8'd1 : 8'd0)) begin
      errors++; $display("FAIL t6_count: got %h exp %h", uo_out, CntEn ? 8'd1 : 8'd0);
    end
    // A LOAD already in flight completes with ena low.
    ui_in = 8'h00; strobe = 1'b1;
    tick();
    ena = 1'b0; strobe = 1'b0;
    tick();
    ena = 1'b1; sel = 2'b00; #1;
    checks++; if (uo_out !== 8'h01) begin errors++; $display("FAIL t6_inflight_lo: got %h exp 01", uo_out); end
    sel = 2'b01; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL t6_inflight_hi: got %h exp 00", uo_out); end
  endtask

  initial begin
    test_reset();
    test_replace();
    test_accumulate();
    test_none_illegal();
    test_held_strobe();
    test_clear_priority();
    test_ena_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
